dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
Direct-mapped, write-back, write-allocate data-cache controller between the MEM stage and a slow line-wide data memory.
- Generates the single mem_stall signal that freezes every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) while a miss is serviced.
- Owns tag/valid/dirty state and the line data array.
- Sequences write-back and refill transactions over a req/ack memory handshake.

Parameters:
ADDR_W, 32, CPU/memory address width
INDEX_W, 4, index bits (16 lines)
OFFSET_W, 5, byte-offset bits (32-byte line)
LINE_W, 256, line width in bits (8 x 32-bit words)
TAG_W, ADDR_W-INDEX_W-OFFSET_W (23), derived; not overridable

Ports:
clk_i  in  1  clock, rising-edge
rst_i  in  1  asynchronous, active-low reset
start_i  in  1  global run enable, same meaning as in the pipeline registers
cpu_req_i  in  1  MEM-stage load/store request
cpu_we_i  in  1  1 = store, 0 = load
cpu_addr_i  in  32  byte address
cpu_wdata_i  in  32  store data
cpu_rdata_o  out  32  load data
mem_stall_o  out  1  stall to all pipeline registers
mem_req_o  out  1  memory transaction request
mem_we_o  out  1  1 = line write-back, 0 = line fetch
mem_addr_o  out  32  line-aligned memory address (low 5 bits 0)
mem_wdata_o  out  256  victim line
mem_rdata_i  in  256  fetched line
mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Address split: tag = addr[31:9], index = addr[8:5], word = addr[4:2]; addr[1:0] ignored (word accesses only).
- Hit condition: valid[index] & (tag_array[index] == tag). Evaluated combinationally in IDLE.
- States: IDLE, WRITEBACK, ALLOCATE. Outputs are Moore-decoded from the state, except for mem_stall_o and cpu_rdata_o.
- IDLE:
  - Load hit: cpu_rdata_o = the selected word, same cycle, zero added latency.
  - Store hit: on the clock edge, write cpu_wdata_i into the word and set dirty[index] = 1.
  - Miss with valid & dirty victim: go to WRITEBACK.
  - Miss otherwise: go to ALLOCATE.
- WRITEBACK:
  - mem_req_o = 1, mem_we_o = 1, mem_addr_o = {victim_tag, index, 5'b0}, mem_wdata_o = victim line.
  - On mem_ack_i go to ALLOCATE.
- ALLOCATE:
  - mem_req_o = 1, mem_we_o = 0, mem_addr_o = {tag, index, 5'b0}.
  - On mem_ack_i: load mem_rdata_i into the line, tag_array = tag, valid = 1, dirty = 0; go to IDLE.
  - The request then hits in IDLE on the next cycle; a store updates the word and sets dirty there.
- mem_stall_o = start_i & cpu_req_i & ((state != IDLE) | ~hit). It deasserts in the first IDLE cycle after the refill.
  - Miss penalty (clean victim) = fetch latency + 1 cycle.
  - Miss penalty (dirty victim) = write-back latency + fetch latency + 1 cycle.
- Handshake:
  - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o stay stable from assertion until the cycle of mem_ack_i inclusive.
  - mem_req_o drops in IDLE.
  - mem_ack_i in IDLE is ignored. Exactly one ack per request.
- The CPU holds cpu_req_i, cpu_addr_i, cpu_we_i and cpu_wdata_i stable while mem_stall_o = 1.
  - If cpu_req_i drops mid-miss, the transaction still completes and the line is installed.
  - No store is performed in that case.
- start_i = 0: state holds; no array writes, no new transactions; mem_stall_o = 0. An in-flight transaction keeps mem_req_o asserted until it is acked.
- Idle outputs: mem_wdata_o = 0 and mem_addr_o = 0 when mem_req_o = 0. cpu_rdata_o = 0 when there is no hit.
- Reset (async, any state, including mid-transaction):
  - state = IDLE; all valid and dirty bits = 0.
  - mem_req_o = 0, mem_we_o = 0, mem_stall_o = 0, cpu_rdata_o = 0.
  - The in-flight transaction is abandoned. Data array contents are don't-care.

Decomposition:
- Shared package: tag/index/word field widths, state encoding constants (IDLE=2'd0, WRITEBACK=2'd1, ALLOCATE=2'd2), LINE_W.
- Sub-module dcache_sram:
  - 16 x 256 data array plus tag/valid/dirty arrays.
  - Inputs: index, word-select write enable, full-line write enable.
  - Outputs: line and tag, combinational reads.
- dcache_ctrl keeps the FSM, hit compare and stall logic.

Test Plan:
- Reset, then load from 0x0000_0040 with a 3-cycle ack latency and mem_rdata_i word2 = 0xDEAD_BEEF, load 0x48. Required: one ALLOCATE with mem_addr_o = 0x40, 4 stall cycles, then cpu_rdata_o = 0xDEAD_BEEF. A repeat load hits with no stall.
- Store 0x1234_5678 to 0x44 (hit after fill), then load 0x244 (same index, different tag). Required: WRITEBACK with mem_addr_o = 0x40 and the line carrying word1 = 0x1234_5678, then ALLOCATE at 0x240, then data returned.
- Store miss to clean index 0x80. Required: ALLOCATE only, no WRITEBACK. After fill the word is updated and dirty = 1; a later eviction writes back the updated line.
- Assert rst_i low during ALLOCATE. Required: mem_req_o and mem_stall_o drop immediately. After release, a load to the same address misses again.
- Stray mem_ack_i pulse in IDLE, and start_i = 0 with cpu_req_i = 1 on a miss address. Required: no state change, mem_req_o = 0, mem_stall_o = 0.
- Back-to-back hit loads to 8 words of one line. Required: 8 consecutive results with zero stall cycles.

Source files
------------

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared field widths and FSM encoding for the data cache
package dcache_pkg;

  localparam int ADDR_W     = 32;
  localparam int INDEX_W    = 4;
  localparam int OFFSET_W   = 5;
  localparam int LINE_W     = 256;
  localparam int WORD_W     = 32;
  localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WORD_SEL_W = OFFSET_W - 2;
  localparam int NUM_LINES  = 1 << INDEX_W;
  localparam int LINE_ID_W  = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

endpackage

// File: rtl/dcache_sram.sv
// rtl/dcache_sram.sv - line data, tag, valid and dirty arrays with combinational read
module dcache_sram
  import dcache_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_W-1:0]    index_i,
  input  logic [WORD_SEL_W-1:0] word_sel_i,
  input  logic                  word_we_i,
  input  logic [WORD_W-1:0]     word_wdata_i,
  input  logic                  line_we_i,
  input  logic [LINE_W-1:0]     line_wdata_i,
  input  logic [TAG_W-1:0]      tag_wdata_i,
  output logic [LINE_W-1:0]     line_o,
  output logic [TAG_W-1:0]      tag_o,
  output logic                  valid_o,
  output logic                  dirty_o
);

  logic [LINE_W-1:0]    data_q [NUM_LINES];
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (line_we_i) begin
      valid_d[index_i] = 1'b1;
      dirty_d[index_i] = 1'b0;
    end else if (word_we_i) begin
      dirty_d[index_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Data and tags carry no reset: valid_q gates every use of them.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      data_q[index_i] <= line_wdata_i;
      tag_q[index_i]  <= tag_wdata_i;
    end else if (word_we_i) begin
      data_q[index_i][word_sel_i*WORD_W +: WORD_W] <= word_wdata_i;
    end
  end

  assign line_o  = data_q[index_i];
  assign tag_o   = tag_q[index_i];
  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate cache controller
// FSM sequences victim write-back and line refill; stall freezes the pipeline meanwhile.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_wdata_i,
  output logic [WORD_W-1:0] cpu_rdata_o,
  output logic              mem_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam logic [OFFSET_W-1:0] OFFSET_ZERO = '0;

  state_e                 state_q, state_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]      mem_wdata_q, mem_wdata_d;
  logic [LINE_ID_W-1:0]   miss_addr_q, miss_addr_d;

  logic [TAG_W-1:0]       cpu_tag;
  logic [INDEX_W-1:0]     cpu_index;
  logic [WORD_SEL_W-1:0]  cpu_word;
  logic [LINE_ID_W-1:0]   cpu_line;
  logic [1:0]             unused_addr_bits;

  logic [INDEX_W-1:0]     sram_index;
  logic [LINE_W-1:0]      sram_line;
  logic [TAG_W-1:0]       sram_tag;
  logic                   sram_valid;
  logic                   sram_dirty;
  logic                   word_we;
  logic                   line_we;
  logic                   hit;
  logic                   hit_idle;

  assign cpu_tag          = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign cpu_index        = cpu_addr_i[OFFSET_W +: INDEX_W];
  assign cpu_word         = cpu_addr_i[2 +: WORD_SEL_W];
  assign cpu_line         = cpu_addr_i[ADDR_W-1:OFFSET_W];
  assign unused_addr_bits = cpu_addr_i[1:0];

  // The refill targets the latched miss line, so the CPU may drop its request mid-miss.
  assign sram_index = (state_q == IDLE) ? cpu_index : miss_addr_q[INDEX_W-1:0];

  dcache_sram u_sram (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .index_i      (sram_index),
    .word_sel_i   (cpu_word),
    .word_we_i    (word_we),
    .word_wdata_i (cpu_wdata_i),
    .line_we_i    (line_we),
    .line_wdata_i (mem_rdata_i),
    .tag_wdata_i  (miss_addr_q[INDEX_W +: TAG_W]),
    .line_o       (sram_line),
    .tag_o        (sram_tag),
    .valid_o      (sram_valid),
    .dirty_o      (sram_dirty)
  );

  assign hit      = sram_valid & (sram_tag == cpu_tag);
  assign hit_idle = (state_q == IDLE) & hit;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    miss_addr_d = miss_addr_q;
    word_we     = 1'b0;
    line_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && cpu_req_i) begin
          if (hit) begin
            word_we = cpu_we_i;
          end else begin
            miss_addr_d = cpu_line;
            mem_req_d   = 1'b1;
            if (sram_valid && sram_dirty) begin
              state_d     = WRITEBACK;
              mem_we_d    = 1'b1;
              mem_addr_d  = {sram_tag, cpu_index, OFFSET_ZERO};
              mem_wdata_d = sram_line;
            end else begin
              state_d     = ALLOCATE;
              mem_we_d    = 1'b0;
              mem_addr_d  = {cpu_line, OFFSET_ZERO};
              mem_wdata_d = '0;
            end
          end
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          // With the pipeline frozen the fetch is parked until start_i returns.
          state_d     = ALLOCATE;
          mem_we_d    = 1'b0;
          mem_wdata_d = '0;
          mem_req_d   = start_i;
          mem_addr_d  = start_i ? {miss_addr_q, OFFSET_ZERO} : '0;
        end
      end
      ALLOCATE: begin
        if (mem_req_q && mem_ack_i) begin
          line_we    = 1'b1;
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_addr_d = '0;
        end else if (!mem_req_q && start_i) begin
          mem_req_d  = 1'b1;
          mem_addr_d = {miss_addr_q, OFFSET_ZERO};
        end
      end
      default: begin
        state_d     = IDLE;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  assign cpu_rdata_o = hit_idle ? sram_line[cpu_word*WORD_W +: WORD_W] : '0;
  assign mem_stall_o = rst_i & start_i & cpu_req_i & (~hit_idle);

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed self-checking bench for dcache_ctrl
module tb_dcache_ctrl;

  localparam int LAT = 3;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         mem_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i;
  logic         mem_ack_i;

  int total = 0;
  int bad   = 0;

  logic [255:0] mem_model [0:63];
  logic         txn_we    [$];
  logic [31:0]  txn_addr  [$];
  logic [255:0] txn_wdata [$];

  dcache_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .mem_stall_o (mem_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] pat(input int line, input int w);
    return 32'hA000_0000 | 32'(line << 8) | 32'(w);
  endfunction

  // Runs one CPU access from posedge+1; memory acks on the LAT-th request cycle.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int stalls, output logic [31:0] rdata);
    int  req_cyc;
    bit  done;
    txn_we.delete();
    txn_addr.delete();
    txn_wdata.delete();
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    stalls  = 0;
    req_cyc = 0;
    done    = 1'b0;
    rdata   = '0;
    #1;
    for (int c = 0; c < 64 && !done; c++) begin
      if (!mem_stall_o) begin
        rdata = cpu_rdata_o;
        done  = 1'b1;
      end else begin
        stalls++;
        if (mem_req_o) begin
          if (req_cyc == 0) begin
            txn_we.push_back(mem_we_o);
            txn_addr.push_back(mem_addr_o);
            txn_wdata.push_back(mem_wdata_o);
          end else begin
            total++;
            if (mem_addr_o !== txn_addr[$] || mem_we_o !== txn_we[$] || mem_wdata_o !== txn_wdata[$]) begin
              bad++;
              $display("FAIL req_stable: got addr=%h we=%b want addr=%h we=%b", mem_addr_o, mem_we_o, txn_addr[$], txn_we[$]);
            end
          end
          req_cyc++;
          if (req_cyc == LAT) begin
            mem_ack_i = 1'b1;
            if (mem_we_o) mem_model[mem_addr_o[10:5]] = mem_wdata_o;
            else          mem_rdata_i = mem_model[mem_addr_o[10:5]];
            req_cyc = 0;
          end
        end
        @(posedge clk_i);
        #1;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL access_timeout: addr=%h still stalled after 64 cycles, want completion", addr);
    end
    @(posedge clk_i);
    #1;
    cpu_req_i = 1'b0;
    cpu_we_i  = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk_i);
    #1;
    total++;
    if (mem_stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", mem_stall_o); end
    total++;
    if (mem_req_o !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", mem_req_o); end
    total++;
    if (cpu_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata_o); end
    cpu_req_i = 1'b0;
    rst_i     = 1'b1;
    @(posedge clk_i);
    #1;
    total++;
    if (mem_addr_o !== 32'h0 || mem_we_o !== 1'b0 || mem_wdata_o !== 256'h0) begin
      bad++; $display("FAIL reset_idle_outs: got addr=%h we=%b want addr=0 we=0 wdata=0", mem_addr_o, mem_we_o);
    end
  endtask

  task automatic test_load_miss;
    int          st;
    logic [31:0] rd;
    access(1'b0, 32'h48, 32'h0, st, rd);
    total++;
    if (st != 4) begin bad++; $display("FAIL miss_stalls: got %0d want 4", st); end
    total++;
    if (txn_addr.size() != 1) begin bad++; $display("FAIL miss_txn_count: got %0d want 1", txn_addr.size()); end
    else if (txn_we[0] !== 1'b0 || txn_addr[0] !== 32'h40) begin
      bad++; $display("FAIL miss_alloc: got we=%b addr=%h want we=0 addr=00000040", txn_we[0], txn_addr[0]);
    end
    total++;
    if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL miss_rdata: got %h want deadbeef", rd); end
    access(1'b0, 32'h48, 32'h0, st, rd);
    total++;
    if (st != 0 || txn_addr.size() != 0) begin bad++; $display("FAIL hit_stalls: got %0d txns=%0d want 0 0", st, txn_addr.size()); end
    total++;
    if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL hit_rdata: got %h want deadbeef", rd); end
  endtask

  task automatic test_store_evict;
    int          st;
    logic [31:0] rd;
    access(1'b1, 32'h44, 32'h1234_5678, st, rd);
    total++;
    if (st != 0) begin bad++; $display("FAIL store_hit_stalls: got %0d want 0", st); end
    access(1'b0, 32'h244, 32'h0, st, rd);
    total++;
    if (st != 7) begin bad++; $display("FAIL evict_stalls: got %0d want 7", st); end
    total++;
    if (txn_addr.size() != 2) begin bad++; $display("FAIL evict_txn_count: got %0d want 2", txn_addr.size()); end
    else begin
      if (txn_we[0] !== 1'b1 || txn_addr[0] !== 32'h40) begin
        bad++; $display("FAIL evict_wb: got we=%b addr=%h want we=1 addr=00000040", txn_we[0], txn_addr[0]);
      end
      total++;
      if (txn_wdata[0][63:32] !== 32'h1234_5678 || txn_wdata[0][95:64] !== 32'hDEAD_BEEF) begin
        bad++; $display("FAIL evict_wb_data: got w1=%h w2=%h want 12345678 deadbeef", txn_wdata[0][63:32], txn_wdata[0][95:64]);
      end
      total++;
      if (txn_we[1] !== 1'b0 || txn_addr[1] !== 32'h240) begin
        bad++; $display("FAIL evict_alloc: got we=%b addr=%h want we=0 addr=00000240", txn_we[1], txn_addr[1]);
      end
    end
    total++;
    if (rd !== 32'hA000_1201) begin bad++; $display("FAIL evict_rdata: got %h want a0001201", rd); end
  endtask

  task automatic test_store_miss;
    int          st;
    logic [31:0] rd;
    access(1'b1, 32'h84, 32'hCAFE_F00D, st, rd);
    total++;
    if (st != 4) begin bad++; $display("FAIL smiss_stalls: got %0d want 4", st); end
    total++;
    if (txn_addr.size() != 1) begin bad++; $display("FAIL smiss_txn_count: got %0d want 1", txn_addr.size()); end
    else if (txn_we[0] !== 1'b0 || txn_addr[0] !== 32'h80) begin
      bad++; $display("FAIL smiss_alloc: got we=%b addr=%h want we=0 addr=00000080", txn_we[0], txn_addr[0]);
    end
    access(1'b0, 32'h84, 32'h0, st, rd);
    total++;
    if (rd !== 32'hCAFE_F00D || st != 0) begin bad++; $display("FAIL smiss_readback: got %h stalls=%0d want cafef00d 0", rd, st); end
    access(1'b0, 32'h284, 32'h0, st, rd);
    total++;
    if (txn_addr.size() != 2) begin bad++; $display("FAIL smiss_evict_count: got %0d want 2", txn_addr.size()); end
    else begin
      if (txn_we[0] !== 1'b1 || txn_addr[0] !== 32'h80) begin
        bad++; $display("FAIL smiss_evict_wb: got we=%b addr=%h want we=1 addr=00000080", txn_we[0], txn_addr[0]);
      end
      total++;
      if (txn_wdata[0][63:32] !== 32'hCAFE_F00D || txn_wdata[0][31:0] !== 32'hA000_0400) begin
        bad++; $display("FAIL smiss_evict_data: got w1=%h w0=%h want cafef00d a0000400", txn_wdata[0][63:32], txn_wdata[0][31:0]);
      end
    end
    total++;
    if (rd !== 32'hA000_1401 || st != 7) begin bad++; $display("FAIL smiss_evict_rdata: got %h stalls=%0d want a0001401 7", rd, st); end
  endtask

  task automatic test_reset_mid;
    int          n;
    int          st;
    logic [31:0] rd;
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'hC0;
    n = 0;
    while (!mem_req_o && n < 8) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    total++;
    if (mem_req_o !== 1'b1) begin bad++; $display("FAIL rmid_req_start: got %b want 1", mem_req_o); end
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    total++;
    if (mem_req_o !== 1'b0 || mem_stall_o !== 1'b0) begin
      bad++; $display("FAIL rmid_drop: got req=%b stall=%b want 0 0", mem_req_o, mem_stall_o);
    end
    cpu_req_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    access(1'b0, 32'hC0, 32'h0, st, rd);
    total++;
    if (st != 4 || txn_addr.size() != 1 || rd !== 32'hA000_0600) begin
      bad++; $display("FAIL rmid_refetch: got stalls=%0d txns=%0d rdata=%h want 4 1 a0000600", st, txn_addr.size(), rd);
    end
    access(1'b0, 32'h244, 32'h0, st, rd);
    total++;
    if (st != 4 || txn_addr.size() != 1 || rd !== 32'hA000_1201) begin
      bad++; $display("FAIL rmid_valid_cleared: got stalls=%0d txns=%0d rdata=%h want 4 1 a0001201", st, txn_addr.size(), rd);
    end
  endtask

  task automatic test_idle_quiet;
    int          st;
    logic [31:0] rd;
    mem_ack_i   = 1'b1;
    mem_rdata_i = '1;
    @(posedge clk_i);
    #1;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    total++;
    if (mem_req_o !== 1'b0 || mem_stall_o !== 1'b0) begin
      bad++; $display("FAIL stray_ack: got req=%b stall=%b want 0 0", mem_req_o, mem_stall_o);
    end
    start_i    = 1'b0;
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h300;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (mem_req_o !== 1'b0 || mem_stall_o !== 1'b0) begin
        bad++; $display("FAIL halt_quiet: got req=%b stall=%b want 0 0", mem_req_o, mem_stall_o);
      end
      @(posedge clk_i);
      #1;
    end
    cpu_we_i    = 1'b1;
    cpu_addr_i  = 32'hC4;
    cpu_wdata_i = 32'hBAD0_BAD0;
    @(posedge clk_i);
    #1;
    cpu_req_i = 1'b0;
    cpu_we_i  = 1'b0;
    start_i   = 1'b1;
    access(1'b0, 32'hC4, 32'h0, st, rd);
    total++;
    if (st != 0 || rd !== 32'hA000_0601) begin bad++; $display("FAIL halt_no_write: got stalls=%0d rdata=%h want 0 a0000601", st, rd); end
    access(1'b0, 32'h300, 32'h0, st, rd);
    total++;
    if (st != 4 || txn_addr.size() != 1 || rd !== 32'hA000_1800) begin
      bad++; $display("FAIL halt_then_miss: got stalls=%0d txns=%0d rdata=%h want 4 1 a0001800", st, txn_addr.size(), rd);
    end
  endtask

  task automatic test_back_to_back;
    cpu_req_i = 1'b1;
    cpu_we_i  = 1'b0;
    for (int w = 0; w < 8; w++) begin
      cpu_addr_i = 32'hC0 + 32'(w * 4);
      #1;
      total++;
      if (mem_stall_o !== 1'b0 || cpu_rdata_o !== pat(6, w)) begin
        bad++; $display("FAIL b2b_word%0d: got stall=%b rdata=%h want 0 %h", w, mem_stall_o, cpu_rdata_o, pat(6, w));
      end
      @(posedge clk_i);
      #1;
    end
    cpu_req_i = 1'b0;
  endtask

  initial begin
    for (int l = 0; l < 64; l++)
      for (int w = 0; w < 8; w++)
        mem_model[l][w*32 +: 32] = pat(l, w);
    mem_model[2][2*32 +: 32] = 32'hDEAD_BEEF;
    rst_i       = 1'b0;
    start_i     = 1'b1;
    cpu_req_i   = 1'b1;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = 32'h40;
    cpu_wdata_i = 32'h0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    test_reset;
    test_load_miss;
    test_store_evict;
    test_store_miss;
    test_reset_mid;
    test_idle_quiet;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
